byte_unstriping_2l: RTL and testbench
=====================================

Name: byte_unstriping_2l

Overview:
- Receive-side 2-lane to 1-lane byte un-striper for the PCIe physical-layer datapath.
- Accepts up to two lane bytes per clock (lane 0, lane 1) from the lane-alignment flops and buffers them in a circular byte buffer.
- Emits one byte per clock in lane order (lane 0 first) under a ready/valid handshake.
- Sits between the per-lane registers and the descrambler/framing logic.

Parameters:
- DEPTH, 8, buffer size in bytes; power of two, >= 4.
- AW, clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  single clock, all state updates on posedge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in0  input  8  lane 0 byte.
- in1  input  8  lane 1 byte.
- valid0  input  1  in0 carries a valid byte.
- valid1  input  1  in1 carries a valid byte.
- in_ready  output  1  buffer can accept a full lane pair this cycle.
- out_data  output  8  un-striped byte stream.
- out_valid  output  1  out_data holds a valid byte.
- out_ready  input  1  downstream accepts out_data this cycle.
- level  output  AW+1  bytes currently buffered, 0..DEPTH.
- err  output  1  sticky protocol-error flag.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. Assertion clears state immediately, with no clock edge needed.
- Reset values:
  - wr_ptr = 0, rd_ptr = 0, level = 0, err = 0.
  - out_valid = 0, out_data = 8'h00, in_ready = 1.
  - Buffer memory is not reset.
- in_ready = (DEPTH - level) >= 2. Combinational from registered level only; it never depends on the valid inputs.
- Write handshake:
  - Occurs when in_ready = 1 and valid0 = 1.
  - valid0 = 1, valid1 = 1: in0 -> mem[wr_ptr], in1 -> mem[wr_ptr+1 mod DEPTH]; wr_ptr += 2.
  - valid0 = 1, valid1 = 0: in0 -> mem[wr_ptr]; wr_ptr += 1 (odd tail of a packet).
  - valid0 = 0, valid1 = 1: illegal. Nothing written, err <= 1. err is sticky and cleared only by reset. The error is flagged regardless of in_ready.
  - Valids asserted while in_ready = 0 are ignored, with no error. The producer holds its data.
- Read side:
  - out_valid = (level != 0).
  - out_data = mem[rd_ptr] when out_valid, else 8'h00 (combinational from registers).
  - Pop occurs when out_valid & out_ready; rd_ptr += 1 on the edge.
- Level update: level_next = level + nwr - pop, where nwr is in {0,1,2}. Write and pop in the same cycle are both applied.
- Latency: a byte written at edge N appears on out_data after edge N. Zero-bubble: a pair written every other cycle with out_ready = 1 streams continuously.
- Ordering: output order is strictly in0 before in1 of the same cycle, then the next accepted cycle.
- Pointers wrap modulo DEPTH. A pair straddling the wrap (wr_ptr = DEPTH-1) writes mem[DEPTH-1], then mem[0].
- Full: level = DEPTH implies in_ready = 0 and out_valid = 1.
- Empty: level = 0 implies out_valid = 0 and out_ready is ignored.
- Level never exceeds DEPTH and never underflows.
- out_valid does not drop while level != 0, regardless of out_ready. out_data is stable while out_valid & !out_ready.

Test Plan:
1. Reset, then one cycle of in0 = A1, in1 = B2, valid0 = valid1 = 1, out_ready = 1. Required: out_data A1, then B2 on consecutive cycles; level 2 -> 1 -> 0; then out_valid = 0 and out_data = 00.
2. DEPTH = 8, out_ready = 0, pairs 00/01, 02/03, ... every cycle. Required: four pairs accepted, level = 8, in_ready = 0, fifth pair ignored. Then out_ready = 1: bytes 00..07 emitted in order.
3. valid0 = 1 with in0 = 3C, valid1 = 0. Required: level = 1, out_data = 3C, err = 0.
4. valid0 = 0, valid1 = 1, in1 = 55. Required: err = 1 next cycle, level unchanged. err stays 1 through later legal traffic until reset.
5. Wrap and simultaneity: out_ready = 1 throughout, twelve consecutive pairs 10/11 .. 26/27 offered. Required:
   - in_ready drops once level reaches 7.
   - Writes resume as level drains.
   - Output is the exact byte sequence 10..27 across pointer wraps, with no loss or duplication.
6. Mid-stream async reset: assert reset low between clock edges while level = 5. Required: level = 0, out_valid = 0, err = 0, in_ready = 1 immediately, with no clock edge. After release, a fresh pair passes as in scenario 1.

Source files
------------

// File: rtl/byte_unstriping_2l.sv
`timescale 1ns/1ps
// Receive-side 2-lane to 1-lane byte un-striper: buffers up to two lane bytes
// per clock in a circular buffer and emits one byte per clock, lane 0 first.
module byte_unstriping_2l #(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    in0,
  input  logic [7:0]    in1,
  input  logic          valid0,
  input  logic          valid1,
  output logic          in_ready,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   level,
  output logic          err
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr_p1;
  logic [AW:0]   level_q;
  logic [AW:0]   nwr;
  logic          err_q;
  logic          wr_en;
  logic          wr_two;
  logic          pop;

  // Handshake decode; everything here derives from registered state plus inputs.
  always_comb begin
    in_ready  = (level_q <= (AW+1)'(DEPTH - 2));
    out_valid = (level_q != '0);
    out_data  = out_valid ? mem[rd_ptr] : 8'h00;
    wr_en     = in_ready & valid0;
    wr_two    = wr_en & valid1;
    nwr       = wr_two ? (AW+1)'(2) : (wr_en ? (AW+1)'(1) : '0);
    pop       = out_valid & out_ready;
    wr_ptr_p1 = wr_ptr + AW'(1);
  end

  assign level = level_q;
  assign err   = err_q;

  // Pointer, level and sticky error state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      err_q   <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr + AW'(nwr);
      rd_ptr  <= rd_ptr + AW'(pop);
      level_q <= level_q + nwr - (AW+1)'(pop);
      err_q   <= err_q | (valid1 & ~valid0);
    end
  end

  // Buffer storage carries no reset; a pair at the last slot wraps lane 1 to slot 0.
  always_ff @(posedge clk) begin
    if (wr_en)  mem[wr_ptr]    <= in0;
    if (wr_two) mem[wr_ptr_p1] <= in1;
  end

endmodule

// File: tb/tb_byte_unstriping_2l.sv
`timescale 1ns/1ps
// Scoreboard bench for byte_unstriping_2l: the driver pushes accepted bytes into
// an expected-byte queue, a forked monitor compares the DUT outputs every cycle.
module tb_byte_unstriping_2l;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic          clk;
  logic          reset;
  logic [7:0]    in0;
  logic [7:0]    in1;
  logic          valid0;
  logic          valid1;
  logic          in_ready;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW:0]   level;
  logic          err;

  byte_unstriping_2l #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in0       (in0),
    .in1       (in1),
    .valid0    (valid0),
    .valid1    (valid1),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] exp_q[$];
  logic       merr;
  int         errors;
  int         checks;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compares every cycle against the reference buffer, pops on accepted output.
  task automatic monitor();
    logic [7:0] front;
    int unsigned sz;
    forever begin
      @(negedge clk);
      #1;
      sz = exp_q.size();
      if (sz != 0) front = exp_q[0];
      else         front = 8'h00;
      chk("out_valid", 32'(out_valid), 32'(sz != 0));
      chk("out_data",  32'(out_data),  32'(front));
      chk("level",     32'(level),     sz);
      chk("in_ready",  32'(in_ready),  32'((DEPTH - sz) >= 2));
      chk("err",       32'(err),       32'(merr));
      if (sz != 0 && out_ready && reset) void'(exp_q.pop_front());
    end
  endtask

  // One producer cycle; acceptance comes from the reference buffer occupancy.
  task automatic drive(input logic v0, input logic v1, input logic [7:0] d0,
                       input logic [7:0] d1, input logic ordy, output logic acc);
    logic ill;
    @(negedge clk);
    valid0 = v0; valid1 = v1; in0 = d0; in1 = d1; out_ready = ordy;
    acc = v0 && ((DEPTH - exp_q.size()) >= 2);
    ill = v1 && !v0;
    #3;
    if (acc) begin
      exp_q.push_back(d0);
      if (v1) exp_q.push_back(d1);
    end
    if (ill) merr = 1'b1;
  endtask

  task automatic drain();
    logic acc;
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, acc);
      n++;
    end
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, acc);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d bytes left, required 0", exp_q.size());
    end
  endtask

  // Asynchronous reset asserted between edges; outputs must clear without a clock.
  task automatic reset_mid();
    @(negedge clk);
    valid0 = 1'b0; valid1 = 1'b0; out_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst_level",     32'(level),     32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_err",       32'(err),       32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_data",  32'(out_data),  32'd0);
    exp_q.delete();
    merr = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
  endtask

  initial begin
    logic acc;
    int t;
    logic v0;
    logic v1;
    errors = 0; checks = 0; merr = 1'b0;
    reset = 1'b0; valid0 = 1'b0; valid1 = 1'b0; in0 = 8'h00; in1 = 8'h00; out_ready = 1'b0;
    #1;
    chk("init_level",    32'(level),     32'd0);
    chk("init_in_ready", 32'(in_ready),  32'd1);
    chk("init_valid",    32'(out_valid), 32'd0);
    chk("init_err",      32'(err),       32'd0);
    fork
      monitor();
    join_none
    @(negedge clk);
    #2 reset = 1'b1;

    // Single pair streams out in lane order.
    drive(1'b1, 1'b1, 8'hA1, 8'hB2, 1'b1, acc);
    drain();

    // Fill to full with output stalled; the fifth pair is refused.
    for (int k = 0; k < 5; k++)
      drive(1'b1, 1'b1, 8'(2*k), 8'(2*k+1), 1'b0, acc);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, acc);
    drain();

    // Odd tail byte.
    drive(1'b1, 1'b0, 8'h3C, 8'h00, 1'b0, acc);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, acc);
    drain();

    // Illegal lane-1-only valid sets sticky err.
    drive(1'b0, 1'b1, 8'h00, 8'h55, 1'b0, acc);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, acc);
    drive(1'b1, 1'b1, 8'h77, 8'h88, 1'b1, acc);
    drain();

    // Continuous pairs with output draining: backpressure and pointer wrap.
    for (int k = 0; k < 12; k++) begin
      t = 0;
      do begin
        drive(1'b1, 1'b1, 8'(8'h10 + 2*k), 8'(8'h11 + 2*k), 1'b1, acc);
        t++;
      end while (!acc && t < 20);
      checks++;
      if (!acc) begin
        errors++;
        $display("FAIL wrap_accept: pair %0d not accepted, required accept within 20 cycles", k);
      end
    end
    drain();

    // Mid-stream reset at level 5, then a fresh pair.
    drive(1'b1, 1'b1, 8'h61, 8'h62, 1'b0, acc);
    drive(1'b1, 1'b1, 8'h63, 8'h64, 1'b0, acc);
    drive(1'b1, 1'b0, 8'h65, 8'h00, 1'b0, acc);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, acc);
    reset_mid();
    drive(1'b1, 1'b1, 8'hA1, 8'hB2, 1'b1, acc);
    drain();

    // Randomized traffic with occasional illegal lane-1-only beats.
    for (int i = 0; i < 400; i++) begin
      v0 = ($urandom % 4) != 0;
      v1 = v0 ? 1'($urandom % 2) : (($urandom % 32) == 0);
      drive(v0, v1, 8'($urandom), 8'($urandom), 1'($urandom % 3 != 0), acc);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
